// File: rtl/pipe_multdiv.sv
// pipe_multdiv: multi-cycle signed multiply (radix-2 Booth) / divide (restoring)
// unit for the execute stage. One bit per clock, WIDTH iterations per operation.
// Optional divider datapath: define MULTDIV_DIV_EN to include it; when undefined a
// divide start completes on the next edge with result 0 and exception set.
module pipe_multdiv #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             op_div;
   logic [WIDTH-1:0] acc;   // Booth upper half / divider partial remainder
   logic [WIDTH-1:0] q;     // Booth multiplier half / dividend-quotient shifter
   logic [WIDTH-1:0] m;     // multiplicand / divisor magnitude
   logic             qm1;   // Booth q[-1]

   logic [WIDTH:0]     booth_sum;
   logic [WIDTH-1:0]   mul_acc, mul_q;
   logic [2*WIDTH-1:0] product;
   logic               mul_exc;

   // One Booth step; the add runs one bit wider so a most-negative multiplicand
   // cannot overflow before the arithmetic shift.
   always_comb begin
      booth_sum = {acc[WIDTH-1], acc};
      case ({q[0], qm1})
         2'b01:   booth_sum = {acc[WIDTH-1], acc} + {m[WIDTH-1], m};
         2'b10:   booth_sum = {acc[WIDTH-1], acc} - {m[WIDTH-1], m};
         default: booth_sum = {acc[WIDTH-1], acc};
      endcase
      mul_acc = booth_sum[WIDTH:1];
      mul_q   = {booth_sum[0], q[WIDTH-1:1]};
      product = {mul_acc, mul_q};
      mul_exc = product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}};
   end

`ifdef MULTDIV_DIV_EN
   logic             neg, div_zero, div_ovf;
   logic [WIDTH:0]   shifted;
   logic             fits;
   logic [WIDTH-1:0] div_acc, div_q, quot;

   // One restoring-divide step on magnitudes, then sign fix-up of the quotient.
   always_comb begin
      shifted = {acc, q[WIDTH-1]};
      fits    = shifted >= {1'b0, m};
      div_acc = fits ? WIDTH'(shifted - {1'b0, m}) : shifted[WIDTH-1:0];
      div_q   = {q[WIDTH-2:0], fits};
      quot    = neg ? -div_q : div_q;
   end
`endif

   // Control FSM and datapath registers; reset beats start, start beats everything else.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         op_div         <= 1'b0;
         acc            <= '0;
         q              <= '0;
         m              <= '0;
         qm1            <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
`ifdef MULTDIV_DIV_EN
         neg            <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
`endif
      end else if (ctrl_MULT || ctrl_DIV) begin
         state          <= RUN;
         cnt            <= '0;
         busy           <= 1'b1;
         data_resultRDY <= 1'b0;
         acc            <= '0;
         qm1            <= 1'b0;
         op_div         <= !ctrl_MULT;
         q              <= data_operandB;
         m              <= data_operandA;
`ifdef MULTDIV_DIV_EN
         if (!ctrl_MULT) begin
            q        <= data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
            m        <= data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
            neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= data_operandB == '0;
            div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
         end
`endif
      end else begin
         case (state)
            RUN: begin
               cnt <= cnt + CW'(1);
`ifdef MULTDIV_DIV_EN
               if (op_div) begin
                  acc <= div_acc;
                  q   <= div_q;
               end else begin
                  acc <= mul_acc;
                  q   <= mul_q;
                  qm1 <= q[0];
               end
               if (cnt == LAST) begin
                  state          <= DONE;
                  busy           <= 1'b0;
                  data_resultRDY <= 1'b1;
                  if (!op_div) begin
                     data_result    <= mul_q;
                     data_exception <= mul_exc;
                  end else if (div_zero) begin
                     data_result    <= '0;
                     data_exception <= 1'b1;
                  end else begin
                     data_result    <= quot;
                     data_exception <= div_ovf;
                  end
               end
`else
               acc <= mul_acc;
               q   <= mul_q;
               qm1 <= q[0];
               if (op_div || cnt == LAST) begin
                  state          <= DONE;
                  busy           <= 1'b0;
                  data_resultRDY <= 1'b1;
                  data_result    <= op_div ? '0 : mul_q;
                  data_exception <= op_div ? 1'b1 : mul_exc;
               end
`endif
            end
            DONE: begin
               data_resultRDY <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_multdiv.sv
// tb_pipe_multdiv: table-driven plus hand-sequenced checks for pipe_multdiv (WIDTH=32).
// Expected divide behaviour follows MULTDIV_DIV_EN when it is defined for the build.
module tb_pipe_multdiv;

   localparam int W = 32;
`ifdef MULTDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic [W-1:0]  data_operandA, data_operandB;
   logic          ctrl_MULT, ctrl_DIV;
   logic [W-1:0]  data_result;
   logic          data_exception, data_resultRDY, busy;

   pipe_multdiv #(.WIDTH(W)) dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit           div;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         exc;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      logic         exc;
      int           cyc;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: 64-bit product / native signed division with the two special cases.
   function automatic logic [W:0] model(input bit div, input logic [W-1:0] a, input logic [W-1:0] b);
      longint p;
      int     qv;
      if (!div) begin
         p = longint'($signed(a)) * longint'($signed(b));
         return {(p[63:32] != {32{p[31]}}), p[31:0]};
      end
      if (!DIV_EN || b == '0) return {1'b1, 32'h0};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
      qv = $signed(a) / $signed(b);
      return {1'b0, qv};
   endfunction

   // Scoreboard consumer: every RDY pulse must match the oldest expectation, including its cycle.
   always @(negedge clock) begin
      if (data_resultRDY === 1'b1) begin
         check("rdy_expected", 64'(sb.size() != 0), 64'(1));
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("result", 64'(data_result), 64'(mon_e.res));
            check("exception", 64'(data_exception), 64'(mon_e.exc));
            check("rdy_cycle", 64'(cyc), 64'(mon_e.cyc));
            check("busy_at_rdy", 64'(busy), 64'(0));
         end
      end
   end

   // Called at a negedge: pulses the start for one cycle, returns at the negedge after start edge N.
   task automatic issue(input bit div, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit track, input logic [W-1:0] res, input logic exc);
      exp_t e;
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = !div;
      ctrl_DIV      = div;
      if (track) begin
         e.res = res;
         e.exc = exc;
         e.cyc = cyc + 1 + ((div && !DIV_EN) ? 1 : W);
         if (div && !DIV_EN) begin
            e.res = '0;
            e.exc = 1'b1;
         end
         sb.push_back(e);
      end
      @(negedge clock);
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom();
      data_operandB = $urandom();
   endtask

   task automatic drain(input string name);
      int budget = 4 * W;
      while (sb.size() != 0 && budget > 0) begin
         @(negedge clock);
         budget--;
      end
      check(name, 64'(sb.size()), 64'(0));
      sb.delete();
   endtask

   initial begin
      logic [W:0] mr;
      logic [W-1:0] ra, rb;
      bit rd;

      // Vectors {div, A, B, result, exception}
      vecs.push_back('{1'b0, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0});
      vecs.push_back('{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0,         1'b1});
      vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b0});
      vecs.push_back('{1'b0, 32'h8000_0000, 32'h1,         32'h8000_0000, 1'b0});
      vecs.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
      vecs.push_back('{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0,         1'b1});
      vecs.push_back('{1'b0, 32'd12345,     32'd6789,      32'd83810205,  1'b0});
      vecs.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
      vecs.push_back('{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0});
      vecs.push_back('{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0});
      vecs.push_back('{1'b1, 32'd100,       32'd0,         32'h0,         1'b1});
      vecs.push_back('{1'b1, 32'd100,       32'd7,         32'd14,        1'b0});
      vecs.push_back('{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        1'b0});
      vecs.push_back('{1'b1, 32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0});
      vecs.push_back('{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0,         1'b0});
      for (int i = 0; i < 12; i++) begin
         rd = (i % 2) == 1;
         ra = $urandom();
         rb = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom();
         mr = model(rd, ra, rb);
         vecs.push_back('{rd, ra, rb, mr[W-1:0], mr[W]});
      end

      reset = 1'b1;
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (2) begin
         @(negedge clock);
         check("reset_outputs", 64'({data_result, data_exception, data_resultRDY, busy}), 64'(0));
      end
      reset = 1'b0;
      repeat (5) begin
         @(negedge clock);
         check("idle_outputs", 64'({data_result, data_exception, data_resultRDY, busy}), 64'(0));
      end

      // 7 x -6 with busy window and single-cycle RDY
      issue(1'b0, 32'd7, 32'hFFFF_FFFA, 1'b1, 32'hFFFF_FFD6, 1'b0);
      for (int i = 0; i < W; i++) begin
         check("busy_run", 64'(busy), 64'(1));
         check("rdy_low_run", 64'(data_resultRDY), 64'(0));
         @(negedge clock);
      end
      check("rdy_high", 64'(data_resultRDY), 64'(1));
      @(negedge clock);
      check("rdy_one_cycle", 64'(data_resultRDY), 64'(0));
      check("result_hold", 64'(data_result), 64'(32'hFFFF_FFD6));
      drain("drain_first");

      // Table, each start at the earliest non-aborting edge
      foreach (vecs[i]) begin
         issue(vecs[i].div, vecs[i].a, vecs[i].b, 1'b1, vecs[i].res, vecs[i].exc);
         drain($sformatf("drain_vec%0d", i));
      end

      // Restart at N+10: aborted op never reports; second completes at N+42
      repeat (2) @(negedge clock);
      issue(1'b0, 32'd3, 32'd5, 1'b0, '0, 1'b0);
      repeat (9) @(negedge clock);
      issue(1'b0, 32'd4, 32'd4, 1'b1, 32'd16, 1'b0);
      drain("drain_restart");

      // Reset on edge N+15 mid-operation
      repeat (2) @(negedge clock);
      issue(DIV_EN, 32'd1000, 32'd7, 1'b0, '0, 1'b0);
      repeat (14) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < W + 8; i++) begin
         check("post_reset_zero", 64'({data_result, data_exception, data_resultRDY, busy}), 64'(0));
         @(negedge clock);
      end
      issue(1'b0, 32'd2, 32'd3, 1'b1, 32'd6, 1'b0);
      drain("drain_after_reset");

      // Restart exactly on completion edge: no RDY, previous result held
      repeat (2) @(negedge clock);
      issue(1'b0, 32'd5, 32'd5, 1'b0, '0, 1'b0);
      repeat (W - 2) @(negedge clock);
      issue(1'b0, 32'd2, 32'd2, 1'b1, 32'd4, 1'b0);
      check("restart_no_rdy", 64'(data_resultRDY), 64'(0));
      check("restart_busy", 64'(busy), 64'(1));
      check("restart_hold", 64'(data_result), 64'(6));
      drain("drain_restart_edge");

      repeat (3) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pipe_multdiv.md
# pipe_multdiv

Parametrised, multi-cycle signed multiply/divide unit for the execute stage of the 5-stage pipelined processor. It starts on a one-cycle `ctrl_MULT`/`ctrl_DIV` pulse and iterates one bit per clock. It raises `busy` so the hazard logic can stall F/D/X, then pulses `data_resultRDY` with the result and an exception flag. The processor writes `data_exception` to `$rstatus`.

## Interface
- `WIDTH`, default 32: operand and result width. Must be ≥ 4. The iteration counter is `$clog2(WIDTH)+1` bits.
- `clock` in 1: master clock. Everything is updated on the rising edge.
- `reset` in 1: synchronous, active-high; sampled on the rising edge of `clock`.
- `data_operandA` in WIDTH: multiplicand or dividend, two's complement. Sampled only on a start edge.
- `data_operandB` in WIDTH: multiplier or divisor, two's complement. Sampled only on a start edge.
- `ctrl_MULT` in 1: start multiply. A one-cycle pulse.
- `ctrl_DIV` in 1: start divide. A one-cycle pulse.
- `data_result` out WIDTH: low WIDTH bits of the product, or the quotient. Holds until the next completion.
- `data_exception` out 1: overflow or divide-by-zero for the last completed operation. Holds like `data_result`.
- `data_resultRDY` out 1: one-cycle completion pulse.
- `busy` out 1: an operation is in flight.

## Operation
- States are IDLE, RUN and DONE. On reset: state is IDLE and every output is 0 (`data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0).
- Start edge: an edge where `ctrl_MULT` or `ctrl_DIV` is 1.
  - Latch the operands and the op, clear the counter, enter RUN, set `busy`=1, and force `data_resultRDY`=0.
  - If both controls are 1, MULT wins.
  - A start is accepted in any state, including RUN. It aborts the in-flight operation, which then never completes.
- Multiply uses radix-2 Booth: a 2·WIDTH+1 product register with one add/sub plus arithmetic shift per RUN edge.
  - `data_exception`=1 when the upper WIDTH bits of the full product are not the sign extension of bit WIDTH-1.
  - `data_result` is always the low WIDTH bits.
- Divide converts to magnitudes and runs a restoring divide with one quotient bit per RUN edge. The quotient is negated if the operand signs differ, so it truncates toward zero. The remainder is discarded.
- Divide boundary cases (both keep full latency):
  - Divisor 0: `data_result`=0, `data_exception`=1.
  - Dividend = most-negative and divisor = −1: `data_result`=most-negative, `data_exception`=1.
- DONE lasts one cycle, with `data_resultRDY`=1 and `busy`=0, then returns to IDLE.
- A `reset` asserted in any state overrides a simultaneous start. It returns the unit to IDLE and clears the outputs, including a held result.

## Timing
- Let N be the start edge. RUN iterations occur on edges N+1 … N+WIDTH.
- On edge N+WIDTH:
  - `data_result` and `data_exception` update.
  - `data_resultRDY` rises and `busy` falls.
- Latency is WIDTH cycles from the start edge to the RDY cycle.
- `data_resultRDY` falls on edge N+WIDTH+1, unless a new start arrives on that edge; in that case it also falls and `busy` rises.
- `busy` is 1 from edge N until edge N+WIDTH.
- A start on edge N+WIDTH is a restart: no RDY pulse, and `data_result` keeps the value from the previous completion.
- Back-to-back operations: the earliest non-aborting start is edge N+WIDTH+1. This gives a throughput of one operation per WIDTH+1 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `MULTDIV_DIV_EN` defined: divider datapath included, behaving as described above.
- `MULTDIV_DIV_EN` undefined: no divider logic.
  - A `ctrl_DIV` start goes directly to DONE on edge N+1, with `data_result`=0, `data_exception`=1 and `data_resultRDY`=1.
  - `busy` is 1 only for the cycle between edge N and edge N+1.
  - Multiply behaviour is unchanged.

## Test plan
All cases use WIDTH=32.
- Reset held for 2 edges, then idle for 5 edges: all outputs are 0 throughout.
- A=7, B=−6, MULT pulse on edge N: `busy` is 1 on edges N…N+31. On edge N+32: RDY=1 for one cycle, result=0xFFFFFFD6 (−42), exception=0.
- A=0x00010000, B=0x00010000, MULT: result=0, exception=1. Then A=0x80000000, B=−1, DIV: result=0x80000000, exception=1.
- Divide sign handling, with `MULTDIV_DIV_EN` defined:
  - A=−7, B=2: result −3.
  - A=7, B=−2: result −3.
  - A=100, B=0: result 0, exception=1, RDY at N+32.
- Restart: start MULT 3×5, then on edge N+10 start MULT 4×4. There is no RDY at N+32. RDY is at N+42 with result 16.
- `reset` pulsed on edge N+15 mid-divide: RDY never asserts. Outputs are 0 from the following cycle onward, and a new MULT 2×3 afterwards returns 6.
